alu_accum_sequencer: RTL and testbench

ALU_ACCUM_SEQUENCER -- requirements
Module: alu_accum_sequencer

---
 rtl/alu_accum_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_accum_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_accum_sequencer.sv
// alu_accum_sequencer
// Drives an external combinational ALU from an 8-bit accumulator and a carry flag.
// Each request either loads the accumulator or runs one ALU operation on it.
// The updated accumulator is then returned as a response.
//
// Handshakes (valid/ready on both sides):
//   A transfer happens on a rising clk edge where valid && ready are both high.
//   The producer holds valid and its payload until that edge.
//   req_ready is high only in IDLE. rsp_valid is high only in RESP.
//   rsp_* stay constant from the moment rsp_valid rises until the transfer edge.
//   Requests offered in ISSUE or RESP are ignored; nothing is queued.
module alu_accum_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_load,
    input  logic [3:0] req_op,
    input  logic [7:0] req_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_c_in,
    output logic [3:0] alu_sel_code,
    input  logic [7:0] alu_result,
    input  logic       alu_c_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic       carry_q, carry_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic       alu_cin_q, alu_cin_d;
    logic [3:0] alu_sel_q, alu_sel_d;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator, carry flag and registered ALU operand bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= 8'd0;
            carry_q   <= 1'b0;
            alu_a_q   <= 8'd0;
            alu_b_q   <= 8'd0;
            alu_cin_q <= 1'b0;
            alu_sel_q <= 4'd0;
        end else begin
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_cin_q <= alu_cin_d;
            alu_sel_q <= alu_sel_d;
        end
    end

    // Next-state, datapath next values and handshake outputs.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_cin_d = alu_cin_q;
        alu_sel_d = alu_sel_q;
        // req_ready is masked during reset so that every output except
        // rsp_zero reads 0 while rst is held.
        req_ready = 1'b0;
        rsp_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    if (req_load) begin
                        // A load bypasses the ALU. The operand registers keep
                        // their old contents.
                        acc_d   = req_data;
                        carry_d = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        // Freeze the operands. They stay stable for the whole
                        // ISSUE cycle while the external ALU settles.
                        alu_a_d   = acc_q;
                        alu_b_d   = req_data;
                        alu_sel_d = req_op;
                        alu_cin_d = carry_q;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // Carry comes only from the ALU. The 8-bit result wraps naturally.
                acc_d   = alu_result;
                carry_d = alu_c_out;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Responses are read straight from the architectural registers. They are
    // constant for as long as RESP is held.
    assign rsp_data     = acc_q;
    assign rsp_carry    = carry_q;
    assign rsp_zero     = (acc_q == 8'd0);
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_c_in     = alu_cin_q;
    assign alu_sel_code = alu_sel_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_alu_accum_sequencer.sv
// Bench for alu_accum_sequencer: external ALU model, queued scoreboard, random traffic.
module tb_alu_accum_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_load = 1'b0;
    logic [3:0] req_op = 4'd0;
    logic [7:0] req_data = 8'd0;
    logic [7:0] alu_a, alu_b;
    logic       alu_c_in;
    logic [3:0] alu_sel_code;
    logic [7:0] alu_result;
    logic       alu_c_out;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_carry, rsp_zero;
    logic [1:0] dbg_state;

    alu_accum_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_op(req_op), .req_data(req_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in), .alu_sel_code(alu_sel_code),
        .alu_result(alu_result), .alu_c_out(alu_c_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .dbg_state_o(dbg_state)
    );

    // ---------------- external ALU (bench-owned) ----------------
    // Returns {carry_out, result}.
    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
        case (op)
            4'd0:    alu_f = {1'b0, a};
            4'd1:    alu_f = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            4'd2:    alu_f = {1'b0, a} + {1'b0, b};
            4'd3:    alu_f = {1'b0, a} - {1'b0, b} - {8'd0, cin};
            4'd4:    alu_f = {1'b0, a & b};
            4'd5:    alu_f = {1'b0, a | b};
            4'd6:    alu_f = {1'b0, a ^ b};
            4'd7:    alu_f = {a, cin};
            4'd8:    alu_f = {a[0], cin, a[7:1]};
            default: alu_f = {1'b0, b};
        endcase
    endfunction

    always_comb {alu_c_out, alu_result} = alu_f(alu_sel_code, alu_a, alu_b, alu_c_in);

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];          // {carry, data}
    int stall_left = 0;

    // Reference model: architectural accumulator/carry plus last ALU operands.
    logic [7:0] m_acc = 8'd0;
    logic       m_carry = 1'b0;
    logic [7:0] m_a = 8'd0, m_b = 8'd0;
    logic       m_cin = 1'b0;
    logic [3:0] m_sel = 4'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 8'd0; m_carry = 1'b0;
        m_a = 8'd0; m_b = 8'd0; m_cin = 1'b0; m_sel = 4'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"},  32'(rsp_data), 32'd0);
        check({tag, "_rsp_carry"}, 32'(rsp_carry), 32'd0);
        check({tag, "_rsp_zero"},  32'(rsp_zero), 32'd1);
        check({tag, "_alu_a"},     32'(alu_a), 32'd0);
        check({tag, "_alu_b"},     32'(alu_b), 32'd0);
        check({tag, "_alu_c_in"},  32'(alu_c_in), 32'd0);
        check({tag, "_alu_sel"},   32'(alu_sel_code), 32'd0);
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a negedge. While the DUT is busy, garbage with valid=1
    // is offered; it must be ignored.
    task automatic wait_ready(output bit ok);
        int waited;
        waited = 0;
        ok = 1'b1;
        while (req_ready !== 1'b1) begin
            if (waited >= 100) begin
                checks++; errors++;
                $display("FAIL req_ready_timeout actual=0 expected=1 t=%0t", $time);
                ok = 1'b0;
                return;
            end
            req_valid = 1'b1;
            req_load  = 1'($urandom);
            req_op    = 4'($urandom);
            req_data  = 8'($urandom);
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic send(input logic load, input logic [3:0] op, input logic [7:0] data);
        bit ok;
        logic [8:0] r;
        wait_ready(ok);
        if (!ok) return;
        req_valid = 1'b1; req_load = load; req_op = op; req_data = data;
        @(posedge clk);
        if (load) begin
            m_acc = data; m_carry = 1'b0;
        end else begin
            m_a = m_acc; m_b = data; m_cin = m_carry; m_sel = op;
            r = alu_f(op, m_acc, data, m_carry);
            m_acc = r[7:0]; m_carry = r[8];
        end
        exp_q.push_back({m_carry, m_acc});
        @(negedge clk);
        req_load = 1'($urandom); req_op = 4'($urandom); req_data = 8'($urandom);
        check("req_ready_busy", 32'(req_ready), 32'd0);
        check("alu_a", 32'(alu_a), 32'(m_a));
        check("alu_b", 32'(alu_b), 32'(m_b));
        check("alu_c_in", 32'(alu_c_in), 32'(m_cin));
        check("alu_sel_code", 32'(alu_sel_code), 32'(m_sel));
        if (load) begin
            check("load_latency_rsp_valid", 32'(rsp_valid), 32'd1);
        end else begin
            check("alu_issue_rsp_valid", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            check("alu_latency_rsp_valid", 32'(rsp_valid), 32'd1);
        end
    endtask

    // ---------------- consumer readiness ----------------
    always begin
        @(negedge clk);
        if (stall_left > 0) begin
            rsp_ready = 1'b0;
            if (rsp_valid) stall_left--;
        end else begin
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor ----------------
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_carry, prev_zero;
    logic [8:0] exp_v;

    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
                check("stall_rsp_data", 32'(rsp_data), 32'(prev_data));
                check("stall_rsp_carry", 32'(rsp_carry), 32'(prev_carry));
                check("stall_rsp_zero", 32'(rsp_zero), 32'(prev_zero));
                check("stall_req_ready", 32'(req_ready), 32'd0);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected actual=%0h expected=none t=%0t", rsp_data, $time);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(exp_v[7:0]));
                    check("rsp_carry", 32'(rsp_carry), 32'(exp_v[8]));
                    check("rsp_zero", 32'(rsp_zero), 32'(exp_v[7:0] == 8'd0));
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
            prev_carry = rsp_carry;
            prev_zero  = rsp_zero;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        int waited;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);

        // Directed: load 7, add 4, subtract 11.
        send(1'b1, 4'd0, 8'd7);
        send(1'b0, 4'd1, 8'd4);
        send(1'b0, 4'd3, 8'd11);

        // Directed: consumer stall of 5 cycles with requests pending.
        wait_ready(ok);
        stall_left = 5;
        send(1'b1, 4'd0, 8'hA5);
        send(1'b0, 4'd2, 8'h70);

        // Directed: reset pulse in ISSUE abandons the transaction.
        wait_ready(ok);
        req_valid = 1'b1; req_load = 1'b0; req_op = 4'd1; req_data = 8'h33;
        @(posedge clk);
        @(negedge clk);
        check("rst_issue_alu_b", 32'(alu_b), 32'h33);
        check("rst_issue_dbg_state", 32'(dbg_state), 32'd1);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_acc", 32'(rsp_data), 32'd0);
        @(negedge clk);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

        // Accumulator after reset starts from 0: add 0x10 with carry-in 0.
        send(1'b0, 4'd1, 8'h10);

        // Random traffic.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 3)
                send(1'b1, 4'd0, 8'($urandom));
            else
                send(1'b0, 4'($urandom_range(0, 15)), 8'($urandom));
            if ($urandom_range(0, 19) == 0) begin
                wait_ready(ok);
                stall_left = $urandom_range(1, 6);
            end
        end

        // Drain.
        waited = 0;
        while ((exp_q.size() != 0 || req_ready !== 1'b1) && waited < 200) begin
            req_valid = 1'b1;
            req_data = 8'($urandom);
            if (req_ready === 1'b1) req_valid = 1'b0;
            @(negedge clk);
            waited++;
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
